// File: rtl/lc3_io_pkg.sv
// Shared constants and types for the LC-3 memory-mapped I/O blocks.
//   KBSR_ADDR_DEFAULT / KBDR_ADDR_DEFAULT : default keyboard register addresses
//   DB_CNT_W                              : debounce counter width
//   db_state_e                            : key debounce FSM states
package lc3_io_pkg;

    localparam logic [15:0] KBSR_ADDR_DEFAULT = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR_DEFAULT = 16'hFE02;

    localparam int unsigned DB_CNT_W = 16;

    typedef enum logic [1:0] {
        DB_UP        = 2'd0,
        DB_WAIT_DOWN = 2'd1,
        DB_DOWN      = 2'd2,
        DB_WAIT_UP   = 2'd3
    } db_state_e;

endpackage

// File: rtl/key_debounce.sv
// Push-button synchronizer + debouncer producing a one-cycle press pulse.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   key_n   : raw asynchronous active-low button
//   press   : registered one-cycle pulse on an accepted press
module key_debounce
    import lc3_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_e           state_q, state_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]          sync_q, sync_d;
    logic [1:0]          vld_q, vld_d;
    logic                armed_q, armed_d;
    logic                press_q, press_d;
    logic                key_hi;

    assign key_hi = sync_q[1];
    assign press  = press_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DB_UP;
            cnt_q   <= '0;
            sync_q  <= 2'b11;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    // vld_q marks when the synchronizer holds real samples rather than reset
    // values; until then plus a full stable-high period, the FSM is disarmed
    // so a key held through reset release cannot register as a press.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        press_d = 1'b0;
        sync_d  = {sync_q[0], key_n};
        vld_d   = {vld_q[0], 1'b1};
        case (state_q)
            DB_UP: begin
                if (!armed_q) begin
                    if (vld_q[1] && key_hi) begin
                        if (cnt_q == LAST) begin
                            armed_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + DB_CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end else if (!key_hi) begin
                    state_d = DB_WAIT_DOWN;
                    cnt_d   = DB_CNT_W'(1);
                end
            end
            DB_WAIT_DOWN: begin
                if (key_hi) begin
                    state_d = DB_UP;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = DB_DOWN;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_CNT_W'(1);
                end
            end
            DB_DOWN: begin
                if (key_hi) begin
                    state_d = DB_WAIT_UP;
                    cnt_d   = DB_CNT_W'(1);
                end
            end
            DB_WAIT_UP: begin
                if (!key_hi) begin
                    state_d = DB_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = DB_UP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DB_CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_UP;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/lc3_kbd_io.sv
// LC-3 keyboard device: KBSR/KBDR registers fed by a debounced push-button.
//   clk, reset       : clock, asynchronous active-low reset
//   addr, data_in    : MAR / MDR
//   we, select       : write strobe, access enable
//   data_out         : combinational read data
//   sw               : switch value captured on a key press
//   key_n            : raw active-low button
//   irq              : keyboard interrupt request
// Build option: define LC3_KBD_IRQ_EN to enable the KBSR interrupt-enable bit
// and irq = ready & ie; otherwise irq is 0, ie reads 0, KBSR writes ignored.
module lc3_kbd_io
    import lc3_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] KBSR_ADDR       = KBSR_ADDR_DEFAULT,
    parameter logic [15:0] KBDR_ADDR       = KBDR_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        we,
    input  logic        select,
    output logic [15:0] data_out,
    input  logic [9:0]  sw,
    input  logic        key_n,
    output logic        irq
);

    logic       press;
    logic       kbsr_hit, kbdr_hit, kbdr_rd;
    logic [9:0] kbdr_q, kbdr_d;
    logic       ready_q, ready_d;
    logic       ovr_q, ovr_d;
    logic       ie_c;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .key_n(key_n),
        .press(press)
    );

    assign kbsr_hit = (addr == KBSR_ADDR);
    assign kbdr_hit = (addr == KBDR_ADDR);
    assign kbdr_rd  = select & ~we & kbdr_hit;

`ifdef LC3_KBD_IRQ_EN
    logic ie_q, ie_d;
    logic unused_data;

    assign unused_data = ^{data_in[15], data_in[13:0]};
    assign ie_c        = ie_q;
    assign irq         = ready_q & ie_q;

    always_comb begin
        ie_d = ie_q;
        if (select && we && kbsr_hit) begin
            ie_d = data_in[14];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_q <= 1'b0;
        end else begin
            ie_q <= ie_d;
        end
    end
`else
    logic unused_data;

    assign unused_data = ^data_in;
    assign ie_c        = 1'b0;
    assign irq         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbdr_q  <= '0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            kbdr_q  <= kbdr_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
        end
    end

    // A KBDR read frees the register, so a press in the same cycle loads
    // the new character and leaves ready set with overrun cleared.
    always_comb begin
        kbdr_d  = kbdr_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        if (kbdr_rd) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (press) begin
            if (!ready_q || kbdr_rd) begin
                kbdr_d  = sw;
                ready_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Read mux.
    always_comb begin
        data_out = 16'h0000;
        if (select && !we) begin
            if (kbsr_hit) begin
                data_out = {ready_q, ie_c, ovr_q, 13'b0};
            end else if (kbdr_hit) begin
                data_out = {6'b0, kbdr_q};
            end
        end
    end

endmodule

// File: tb/tb_lc3_kbd_io.sv
// Self-checking bench for lc3_kbd_io: vector table, directed multi-cycle
// sequences and a randomized register-level scoreboard.
module tb_lc3_kbd_io;

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        we;
    logic        select;
    logic [15:0] data_out;
    logic [9:0]  sw;
    logic        key_n;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    // Register-level model of the device.
    logic        m_ready, m_ovr, m_ie;
    logic [15:0] m_kbdr;

    lc3_kbd_io dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .data_in (data_in),
        .we      (we),
        .select  (select),
        .data_out(data_out),
        .sw      (sw),
        .key_n   (key_n),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;     // 0 read, 1 write, 2 press
        logic [15:0] a;
        logic [15:0] wd;
        logic [9:0]  s;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] a,
                                input logic [15:0] wd, input logic [9:0] s,
                                input logic [15:0] exp);
        vec_t v;
        v.op = op; v.a = a; v.wd = wd; v.s = s; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        if (a == KBSR) return {m_ready, m_ie, m_ovr, 13'b0};
        if (a == KBDR) return m_kbdr;
        return 16'h0000;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        select = 1'b1; we = 1'b0; addr = a;
        #1 v = data_out;
        @(posedge clk);
        #1 select = 1'b0; addr = 16'h0000;
        if (a == KBDR) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        select = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1 select = 1'b0; we = 1'b0; addr = 16'h0000; data_in = 16'h0000;
`ifdef LC3_KBD_IRQ_EN
        if (a == KBSR) m_ie = d[14];
`endif
    endtask

    task automatic press(input logic [9:0] s);
        sw = s; key_n = 1'b0;
        step(20);
        key_n = 1'b1;
        step(22);
        if (m_ready) m_ovr = 1'b1;
        else begin
            m_kbdr  = {6'b0, s};
            m_ready = 1'b1;
        end
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a);
        logic [15:0] e, v;
        e = model_rd(a);
        rd(a, v);
        chk(nm, v, e);
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] ra, rdat;

        reset = 1'b0; addr = 16'h0000; data_in = 16'h0000; we = 1'b0;
        select = 1'b0; sw = 10'h000; key_n = 1'b1;
        m_ready = 1'b0; m_ovr = 1'b0; m_ie = 1'b0; m_kbdr = 16'h0000;

        tbl[0]  = mk(2'd0, KBSR,     16'h0000, 10'h000, 16'h0000);
        tbl[1]  = mk(2'd0, KBDR,     16'h0000, 10'h000, 16'h0000);
        tbl[2]  = mk(2'd0, 16'h1234, 16'h0000, 10'h000, 16'h0000);
        tbl[3]  = mk(2'd2, 16'h0000, 16'h0000, 10'h001, 16'h0000);
        tbl[4]  = mk(2'd2, 16'h0000, 16'h0000, 10'h3FF, 16'h0000);
        tbl[5]  = mk(2'd0, KBSR,     16'h0000, 10'h000, 16'hA000);
        tbl[6]  = mk(2'd0, KBDR,     16'h0000, 10'h000, 16'h0001);
        tbl[7]  = mk(2'd0, KBSR,     16'h0000, 10'h000, 16'h0000);
        tbl[8]  = mk(2'd1, 16'hFE04, 16'hFFFF, 10'h000, 16'h0000);
        tbl[9]  = mk(2'd1, KBDR,     16'hFFFF, 10'h000, 16'h0000);
        tbl[10] = mk(2'd0, 16'hFE04, 16'h0000, 10'h000, 16'h0000);
        tbl[11] = mk(2'd2, 16'h0000, 16'h0000, 10'h155, 16'h0000);
        tbl[12] = mk(2'd0, KBSR,     16'h0000, 10'h000, 16'h8000);
        tbl[13] = mk(2'd0, 16'hFE01, 16'h0000, 10'h000, 16'h0000);
        tbl[14] = mk(2'd0, KBDR,     16'h0000, 10'h000, 16'h0155);
        tbl[15] = mk(2'd0, KBSR,     16'h0000, 10'h000, 16'h0000);

        // Values while held in reset.
        step(3);
        select = 1'b1; addr = KBSR;
        #1 chk("reset_kbsr", data_out, 16'h0000);
        chk("reset_irq", {15'b0, irq}, 16'h0000);
        addr = KBDR;
        #1 chk("reset_kbdr", data_out, 16'h0000);
        @(posedge clk);
        #1 select = 1'b0; addr = 16'h0000;
        reset = 1'b1;
        step(25);

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            case (tbl[i].op)
                2'd0: begin
                    rd(tbl[i].a, v);
                    chk($sformatf("vec%0d_rd", i), v, tbl[i].exp);
                    chk($sformatf("vec%0d_irq", i), {15'b0, irq}, 16'h0000);
                end
                2'd1: wr(tbl[i].a, tbl[i].wd);
                default: press(tbl[i].s);
            endcase
        end

        // Press acceptance latency with 16-cycle debounce.
        sw = 10'h2A5; key_n = 1'b0; select = 1'b1; addr = KBSR;
        step(17);
        chk("lat_not_yet", {15'b0, data_out[15]}, 16'h0000);
        step(2);
        chk("lat_ready", {15'b0, data_out[15]}, 16'h0001);
        step(1);
        key_n = 1'b1; select = 1'b0; addr = 16'h0000;
        step(22);
        m_ready = 1'b1; m_kbdr = 16'h02A5;
        rd(KBSR, v); chk("lat_kbsr", v, 16'h8000);
        rd(KBDR, v); chk("lat_kbdr", v, 16'h02A5);

        // Bouncing key: short low pulses never qualify.
        sw = 10'h111;
        for (int i = 0; i < 4; i++) begin
            key_n = 1'b0; step(10);
            key_n = 1'b1; step(3);
        end
        step(22);
        rd(KBSR, v); chk("bounce_kbsr", v, 16'h0000);

        // KBDR read coinciding with the press pulse, overrun pending.
        press(10'h100);
        press(10'h200);
        rd(KBSR, v); chk("ovr_kbsr", v, 16'hA000);
        sw = 10'h055; key_n = 1'b0;
        step(18);
        rd(KBDR, v); chk("coinc_old_kbdr", v, 16'h0100);
        step(1);
        key_n = 1'b1;
        step(22);
        m_ready = 1'b1; m_ovr = 1'b0; m_kbdr = 16'h0055;
        rd(KBSR, v); chk("coinc_kbsr", v, 16'h8000);
        rd(KBDR, v); chk("coinc_kbdr", v, 16'h0055);

        // Interrupt enable and irq.
        wr(KBSR, 16'h4000);
        rd_chk("ie_kbsr", KBSR);
        chk("ie_irq_idle", {15'b0, irq}, 16'h0000);
        press(10'h003);
        chk("ie_irq_press", {15'b0, irq}, {15'b0, m_ready & m_ie});
        rd_chk("ie_kbsr_rdy", KBSR);
        rd_chk("ie_kbdr", KBDR);
        chk("ie_irq_clear", {15'b0, irq}, 16'h0000);
        wr(KBSR, 16'h0000);

        // Reset in the middle of a debounce with ready set.
        press(10'h0C3);
        key_n = 1'b0;
        step(8);
        reset = 1'b0;
        select = 1'b1; addr = KBSR;
        #1 chk("midrst_kbsr", data_out, 16'h0000);
        chk("midrst_irq", {15'b0, irq}, 16'h0000);
        addr = KBDR;
        #1 chk("midrst_kbdr", data_out, 16'h0000);
        @(posedge clk);
        #1 select = 1'b0; addr = 16'h0000;
        m_ready = 1'b0; m_ovr = 1'b0; m_ie = 1'b0; m_kbdr = 16'h0000;
        reset = 1'b1;
        step(40);
        rd(KBSR, v); chk("held_key_kbsr", v, 16'h0000);
        key_n = 1'b1;
        step(25);
        press(10'h0AA);
        rd(KBSR, v); chk("repress_kbsr", v, 16'h8000);
        rd(KBDR, v); chk("repress_kbdr", v, 16'h00AA);

        // Randomized operations against the register model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: press(10'($urandom_range(0, 1023)));
                1: rd_chk("rnd_kbsr", KBSR);
                2: rd_chk("rnd_kbdr", KBDR);
                3: wr(KBSR, 16'($urandom));
                4: begin
                    ra = ($urandom_range(0, 1) == 0) ? KBDR : 16'($urandom);
                    if (ra == KBSR) ra = 16'h0000;
                    rdat = 16'($urandom);
                    wr(ra, rdat);
                end
                default: begin
                    ra = 16'($urandom);
                    if (ra == KBSR || ra == KBDR) ra = ra ^ 16'h0100;
                    rd_chk("rnd_other", ra);
                end
            endcase
            chk("rnd_irq", {15'b0, irq}, {15'b0, m_ready & m_ie});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
